// File: rtl/vadd_pkg.sv
// Shared constants and FSM encoding for the vadd dispatch controller and its lane helpers.
// Pure declarations; no timing or flow control.
package vadd_pkg;
  localparam int ADDR_W    = 48;
  localparam int DATA_W    = 64;
  localparam int LANE_W    = DATA_W;
  localparam int GUARD_CYC = 8;
  localparam int CNT_W     = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_KICK = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_RED  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_ARM  = ST_ARM,
    S_KICK = ST_KICK,
    S_WAIT = ST_WAIT,
    S_RED  = ST_RED,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/vadd_dispatch_if.sv
// Job request, lane broadcast and lane result signals between the dispatcher and its environment.
// master is the dispatcher's view; slave is the host/lane-array view.
interface vadd_dispatch_if #(
  parameter int NUM_UNITS = 4,
  parameter int TMO_W     = 32
);
  import vadd_pkg::*;

  logic                        start;
  logic [ADDR_W-1:0]           mem_base1;
  logic [ADDR_W-1:0]           mem_base2;
  logic [ADDR_W-1:0]           mem_base3;
  logic [ADDR_W-1:0]           mem_last_offst;
  logic [TMO_W-1:0]            tmo_limit;
  logic                        u_idle;
  logic                        u_start;
  logic [ADDR_W-1:0]           u_base1;
  logic [ADDR_W-1:0]           u_base2;
  logic [ADDR_W-1:0]           u_base3;
  logic [ADDR_W-1:0]           u_last_offst;
  logic [NUM_UNITS*DATA_W-1:0] u_sum;
  logic [NUM_UNITS-1:0]        u_sum_vld;
  logic [NUM_UNITS-1:0]        u_sum_ovrflw;
  logic [NUM_UNITS-1:0]        u_res_ovrflw;
  logic                        busy;
  logic                        done;
  logic [DATA_W-1:0]           total;
  logic                        total_ovrflw;
  logic                        elem_ovrflw;
  logic                        timeout;

  modport master (
    input  start, mem_base1, mem_base2, mem_base3, mem_last_offst, tmo_limit,
    input  u_sum, u_sum_vld, u_sum_ovrflw, u_res_ovrflw,
    output u_idle, u_start, u_base1, u_base2, u_base3, u_last_offst,
    output busy, done, total, total_ovrflw, elem_ovrflw, timeout
  );

  modport slave (
    output start, mem_base1, mem_base2, mem_base3, mem_last_offst, tmo_limit,
    output u_sum, u_sum_vld, u_sum_ovrflw, u_res_ovrflw,
    input  u_idle, u_start, u_base1, u_base2, u_base3, u_last_offst,
    input  busy, done, total, total_ovrflw, elem_ovrflw, timeout
  );
endinterface

// File: rtl/vadd_lane_settle.sv
// Per-lane settle filter: captures sum/overflow once sum_vld has been high SETTLE enabled cycles in a row.
// Capture lands on the edge ending the SETTLE-th high cycle; a captured lane holds until clear.
module vadd_lane_settle
  import vadd_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              sum_vld,
  input  logic [LANE_W-1:0] sum,
  input  logic              sum_ovrflw,
  output logic [LANE_W-1:0] cap_sum,
  output logic              cap_ovrflw,
  output logic              captured
);
  localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt        <= '0;
      cap_sum    <= '0;
      cap_ovrflw <= 1'b0;
      captured   <= 1'b0;
    end else if (enable) begin
      if (!sum_vld)
        cnt <= '0;
      else if (cnt != SETTLE_C)
        cnt <= cnt + CNT_W'(1);
      // The edge that brings the count to SETTLE is the capture edge.
      if (sum_vld && (cnt == SETTLE_M1) && !captured) begin
        cap_sum    <= sum;
        cap_ovrflw <= sum_ovrflw;
        captured   <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/vadd_dispatch.sv
// Sequences NUM_UNITS vadd lanes on one job and reduces their settled sums into a 64-bit total.
// start->u_start 2 cycles, last capture->done NUM_UNITS+1 cycles; start is dropped while busy.
module vadd_dispatch
  import vadd_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int SETTLE    = 4,
  parameter int TMO_W     = 32
) (
  input logic            clk,
  input logic            reset,
  vadd_dispatch_if.master bus
);
  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   guard_q;
  logic [TMO_W-1:0]   wd_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_UNITS-1:0] captured;
  logic [NUM_UNITS-1:0] cap_ovf;
  logic [DATA_W-1:0]  cap_sum [NUM_UNITS];
  logic               all_done, wd_expire, lane_en, lane_clr;
  logic [DATA_W:0]    red_sum;

  assign all_done  = &captured;
  assign wd_expire = (bus.tmo_limit != '0) && (wd_q == bus.tmo_limit - TMO_W'(1));
  assign lane_en   = (state_q == S_WAIT) && (guard_q == '0);
  assign lane_clr  = (state_q == S_KICK);
  assign red_sum   = {1'b0, bus.total} + {1'b0, cap_sum[idx_q]};

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
    vadd_lane_settle #(.SETTLE(SETTLE)) u_settle (
      .clk        (clk),
      .reset      (reset),
      .clear      (lane_clr),
      .enable     (lane_en),
      .sum_vld    (bus.u_sum_vld[i]),
      .sum        (bus.u_sum[i*DATA_W +: DATA_W]),
      .sum_ovrflw (bus.u_sum_ovrflw[i]),
      .cap_sum    (cap_sum[i]),
      .cap_ovrflw (cap_ovf[i]),
      .captured   (captured[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_ARM;
      S_ARM:  state_d = S_KICK;
      S_KICK: state_d = S_WAIT;
      S_WAIT: if (all_done || wd_expire) state_d = S_RED;
      S_RED:  if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes stay out of idle through DONE; returning to IDLE resets their datapaths.
  always_comb begin
    bus.u_idle  = (state_q == S_IDLE);
    bus.u_start = (state_q == S_KICK);
    bus.done    = (state_q == S_DONE);
    bus.busy    = !((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      guard_q          <= '0;
      wd_q             <= '0;
      idx_q            <= '0;
      bus.u_base1      <= '0;
      bus.u_base2      <= '0;
      bus.u_base3      <= '0;
      bus.u_last_offst <= '0;
      bus.total        <= '0;
      bus.total_ovrflw <= 1'b0;
      bus.elem_ovrflw  <= 1'b0;
      bus.timeout      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          bus.u_base1      <= bus.mem_base1;
          bus.u_base2      <= bus.mem_base2;
          bus.u_base3      <= bus.mem_base3;
          bus.u_last_offst <= bus.mem_last_offst;
          bus.total        <= '0;
          bus.total_ovrflw <= 1'b0;
          bus.elem_ovrflw  <= 1'b0;
          bus.timeout      <= 1'b0;
          wd_q             <= '0;
        end
        S_ARM: wd_q <= wd_q + TMO_W'(1);
        S_KICK: begin
          wd_q    <= wd_q + TMO_W'(1);
          guard_q <= GUARD_LD;
          idx_q   <= '0;
        end
        S_WAIT: begin
          wd_q <= wd_q + TMO_W'(1);
          if (guard_q != '0) guard_q <= guard_q - CNT_W'(1);
          if (!all_done && wd_expire) bus.timeout <= 1'b1;
        end
        // Uncaptured lanes were cleared in KICK, so they add zero here.
        S_RED: begin
          bus.total        <= red_sum[DATA_W-1:0];
          bus.total_ovrflw <= bus.total_ovrflw | red_sum[DATA_W] | cap_ovf[idx_q];
          idx_q            <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
      if (state_q != S_IDLE)
        bus.elem_ovrflw <= bus.elem_ovrflw | (|bus.u_res_ovrflw);
    end
  end
endmodule
